normalizador_seq: RTL and testbench
===================================

Name: normalizador_seq

Overview:
- Multi-cycle normalization stage of the float adder. Sits directly upstream of the rounding stage (arredondamento).
- Takes the raw 27-bit adder result (carry + 26-bit fraction with guard/round/sticky in [2:0]) and its exponent.
- Shifts one position per clock until the leading one sits at bit 25, then presents a registered result with a done pulse.

Parameters:
- FRACT_W, 26, fraction width including the 3 GRS bits
- EXP_W, 8, exponent width
- EXP_MAX, 255, all-ones exponent; also the overflow code

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- carry_in  in  1  carry-out of the adder (bit 26 of the sum)
- fract_in  in  FRACT_W  adder sum bits [25:0]
- exp_in  in  EXP_W  common (aligned) exponent
- busy  out  1  high while in NORM
- done  out  1  one-cycle pulse; result valid
- fract_out  out  FRACT_W  normalized fraction, leading one at bit 25
- exp_out  out  EXP_W  adjusted exponent
- overflow  out  1  exponent reached EXP_MAX
- underflow  out  1  exponent floor hit before normalization finished
- zero  out  1  fraction was all zero

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high (reset, sampled on rising clk).
- Reset state: IDLE. busy=0, done=0, fract_out=0, exp_out=0, overflow=0, underflow=0, zero=0.
- Reset has priority over everything. It aborts an in-flight operation and returns to IDLE with all outputs cleared.
- State machine: IDLE, NORM, DONE.
- IDLE, start=1:
  - Load carry_in, fract_in, exp_in into working registers.
  - Clear the flags.
  - Go to NORM.
- NORM evaluates in priority order, one action per cycle:
  1. carry=1 and exp=EXP_MAX-1: exp=EXP_MAX, fract=0, overflow=1, go DONE.
  2. carry=1: right shift fract={1, fract[25:1]} with sticky fract[0]=fract[1]|fract[0]; exp+1; carry=0. Stay in NORM.
  3. fract=0: zero=1, exp=0, go DONE.
  4. fract[25]=1: go DONE.
  5. exp<=1: underflow=1, leave fract/exp as-is, go DONE.
  6. Otherwise: left shift fract={fract[24:0],0}; exp-1. Stay in NORM.
- If exp_in=EXP_MAX at load, overflow=1 and fract=0 on the first NORM cycle, then DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- fract_out/exp_out/flags are registered. They update on entry to DONE and hold until the next accepted start or reset.
- Latency: start sampled at edge 0 → done high during cycle 2+k, where k is the number of shift cycles (k=0..25; k=1 for the carry case).
- start while busy or in DONE is ignored; no queueing.
- Exponent arithmetic is unsigned EXP_W. No wrap is possible given rules 1 and 5.

Decomposition:
- Shared package float_pkg:
  - FRACT_W, EXP_W, EXP_MAX
  - GRS bit index constants (GUARD=2, ROUND=1, STICKY=0)
  - norm_state_t enum {IDLE, NORM, DONE}
  - The rounding stage reuses FRACT_W/EXP_W from it.
- No sub-module. The shift/decide datapath is a single always block plus the FSM register.

Test Plan:
- Already normalized: carry_in=0, fract_in=26'h2000008, exp_in=8'd127 → done at cycle 2; fract_out=26'h2000008, exp_out=127, all flags 0.
- Carry: carry_in=1, fract_in=26'h0000003, exp_in=100 → done at cycle 3; fract_out=26'h2000001 (sticky kept), exp_out=101.
- Leading one at bit 20: fract_in=26'h0100000, exp_in=50 → 5 shifts, done at cycle 7; fract_out=26'h2000000, exp_out=45; busy high cycles 1-6.
- Zero and underflow:
  - fract_in=0, exp_in=80 → done at cycle 2; zero=1, exp_out=0, fract_out=0.
  - fract_in=26'h0000010, exp_in=3 → 2 shifts, then underflow=1, exp_out=1, fract_out=26'h0000040.
- Overflow: carry_in=1, fract_in=26'h3FFFFFF, exp_in=254 → done at cycle 2; overflow=1, exp_out=255, fract_out=0.
- Control:
  - Second start during busy → ignored; first result unchanged.
  - reset asserted mid-NORM → next cycle IDLE, all outputs 0, no done pulse.

Source files
------------

// File: rtl/float_pkg.sv
// rtl/float_pkg.sv - shared float adder widths, GRS indices and normalizer types
//
// Shared by the normalization stage (normalizador_seq) and the rounding stage
// (arredondamento). No ports; compile-time declarations only.
//   FRACT_W      fraction width including the guard/round/sticky bits
//   EXP_W        exponent width
//   EXP_MAX      all-ones exponent, also used as the overflow code
//   GUARD/ROUND/STICKY  bit positions of the GRS bits inside the fraction
//   norm_state_t normalizer FSM states
//   norm_act_t   the single action the normalizer takes in a NORM cycle

package float_pkg;

  localparam int FRACT_W = 26;
  localparam int EXP_W   = 8;
  localparam int EXP_MAX = 255;

  localparam int GUARD  = 2;
  localparam int ROUND  = 1;
  localparam int STICKY = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } norm_state_t;

  // Listed in decision priority order.
  typedef enum logic [2:0] {
    ACT_OVF  = 3'd0,
    ACT_SHR  = 3'd1,
    ACT_ZERO = 3'd2,
    ACT_FIN  = 3'd3,
    ACT_UNF  = 3'd4,
    ACT_SHL  = 3'd5
  } norm_act_t;

endpackage

// File: rtl/normalizador_seq.sv
// rtl/normalizador_seq.sv - multi-cycle normalization stage of the float adder
//
// Shifts the raw adder result one position per clock until the leading one
// sits at the top fraction bit, then presents a registered result for one
// cycle with a done pulse.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high reset
//   start      in   request, only sampled while idle
//   carry_in   in   carry-out of the adder (bit FRACT_W of the sum)
//   fract_in   in   adder sum bits [FRACT_W-1:0], GRS in [2:0]
//   exp_in     in   common (aligned) exponent
//   busy       out  high while normalizing
//   done       out  one-cycle pulse, result valid
//   fract_out  out  normalized fraction
//   exp_out    out  adjusted exponent
//   overflow   out  exponent reached EXP_MAX
//   underflow  out  exponent floor hit before normalization finished
//   zero       out  fraction was all zero

module normalizador_seq
  import float_pkg::*;
#(
  parameter int FRACT_W = float_pkg::FRACT_W,
  parameter int EXP_W   = float_pkg::EXP_W,
  parameter int EXP_MAX = float_pkg::EXP_MAX
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               carry_in,
  input  logic [FRACT_W-1:0] fract_in,
  input  logic [EXP_W-1:0]   exp_in,
  output logic               busy,
  output logic               done,
  output logic [FRACT_W-1:0] fract_out,
  output logic [EXP_W-1:0]   exp_out,
  output logic               overflow,
  output logic               underflow,
  output logic               zero
);

  localparam logic [EXP_W-1:0] EXP_TOP    = EXP_W'(EXP_MAX);
  localparam logic [EXP_W-1:0] EXP_TOP_M1 = EXP_W'(EXP_MAX - 1);
  localparam logic [EXP_W-1:0] EXP_ONE    = EXP_W'(1);

  norm_state_t        state;
  logic               carry_r;
  logic [FRACT_W-1:0] fract_r;
  logic [EXP_W-1:0]   exp_r;

  norm_act_t          act;
  logic [FRACT_W-1:0] fract_shr;
  logic [FRACT_W-1:0] fract_shl;

  // Right shift brings the carry in at the top; the bit shifted out of the
  // round position is folded into sticky so rounding still sees it.
  always_comb begin
    fract_shr         = {1'b1, fract_r[FRACT_W-1:1]};
    fract_shr[STICKY] = fract_r[ROUND] | fract_r[STICKY];
    fract_shl         = {fract_r[FRACT_W-2:0], 1'b0};
  end

  // One decision per NORM cycle. An exponent already at EXP_MAX can only come
  // straight from the load (rule 1 leaves NORM immediately), so it is checked
  // first and treated as overflow. The exp<=1 floor guarantees the left-shift
  // decrement never wraps.
  always_comb begin
    act = ACT_SHL;
    if (exp_r == EXP_TOP) begin
      act = ACT_OVF;
    end else if (carry_r && (exp_r == EXP_TOP_M1)) begin
      act = ACT_OVF;
    end else if (carry_r) begin
      act = ACT_SHR;
    end else if (fract_r == '0) begin
      act = ACT_ZERO;
    end else if (fract_r[FRACT_W-1]) begin
      act = ACT_FIN;
    end else if (exp_r <= EXP_ONE) begin
      act = ACT_UNF;
    end else begin
      act = ACT_SHL;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      carry_r   <= 1'b0;
      fract_r   <= '0;
      exp_r     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fract_out <= '0;
      exp_out   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      zero      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            carry_r   <= carry_in;
            fract_r   <= fract_in;
            exp_r     <= exp_in;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            zero      <= 1'b0;
            busy      <= 1'b1;
            state     <= NORM;
          end
        end

        NORM: begin
          case (act)
            ACT_SHR: begin
              fract_r <= fract_shr;
              exp_r   <= exp_r + EXP_ONE;
              carry_r <= 1'b0;
            end
            ACT_SHL: begin
              fract_r <= fract_shl;
              exp_r   <= exp_r - EXP_ONE;
            end
            ACT_OVF: begin
              fract_out <= '0;
              exp_out   <= EXP_TOP;
              overflow  <= 1'b1;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end
            ACT_ZERO: begin
              fract_out <= '0;
              exp_out   <= '0;
              zero      <= 1'b1;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end
            ACT_UNF: begin
              fract_out <= fract_r;
              exp_out   <= exp_r;
              underflow <= 1'b1;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end
            default: begin
              fract_out <= fract_r;
              exp_out   <= exp_r;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end
          endcase
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_normalizador_seq.sv
// tb/tb_normalizador_seq.sv - self-checking bench for normalizador_seq

module tb_normalizador_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic        carry_in;
  logic [25:0] fract_in;
  logic [7:0]  exp_in;
  logic        busy;
  logic        done;
  logic [25:0] fract_out;
  logic [7:0]  exp_out;
  logic        overflow;
  logic        underflow;
  logic        zero;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [25:0] f;
    logic [7:0]  e;
    logic        ov;
    logic        uf;
    logic        z;
    int          lat;
  } exp_t;

  exp_t sb[$];

  normalizador_seq dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .carry_in (carry_in),
    .fract_in (fract_in),
    .exp_in   (exp_in),
    .busy     (busy),
    .done     (done),
    .fract_out(fract_out),
    .exp_out  (exp_out),
    .overflow (overflow),
    .underflow(underflow),
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".busy"},      {31'd0, busy},      32'd0);
    check({tag, ".done"},      {31'd0, done},      32'd0);
    check({tag, ".fract_out"}, {6'd0, fract_out},  32'd0);
    check({tag, ".exp_out"},   {24'd0, exp_out},   32'd0);
    check({tag, ".overflow"},  {31'd0, overflow},  32'd0);
    check({tag, ".underflow"}, {31'd0, underflow}, 32'd0);
    check({tag, ".zero"},      {31'd0, zero},      32'd0);
  endtask

  // Start one operation (sampled at edge 0), push its expectation, then wait
  // for done counting cycles. inject_at > 0 fires a second start in that cycle.
  task automatic run_op(input string name, input logic c, input logic [25:0] f,
                        input logic [7:0] e, input logic [25:0] ef, input logic [7:0] ee,
                        input logic eo, input logic eu, input logic ez,
                        input int lat, input int inject_at);
    exp_t x;
    int   cyc;
    bit   seen;
    int   extra;
    x.f = ef; x.e = ee; x.ov = eo; x.uf = eu; x.z = ez; x.lat = lat;
    sb.push_back(x);
    @(negedge clk);
    carry_in = c; fract_in = f; exp_in = e; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    seen = 1'b0;
    while (cyc <= 40 && !seen) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        check({name, ".busy"}, {31'd0, busy}, 32'd1);
        if (cyc == inject_at) begin
          start = 1'b1; carry_in = 1'b0; fract_in = 26'h0000001; exp_in = 8'd9;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    if (!seen) begin
      check({name, ".done_timeout"}, 32'd0, 32'd1);
      if (sb.size() != 0) void'(sb.pop_front());
    end else if (sb.size() == 0) begin
      check({name, ".sb_empty"}, 32'd0, 32'd1);
    end else begin
      x = sb.pop_front();
      check({name, ".latency"},   cyc,                x.lat);
      check({name, ".fract_out"}, {6'd0, fract_out},  {6'd0, x.f});
      check({name, ".exp_out"},   {24'd0, exp_out},   {24'd0, x.e});
      check({name, ".overflow"},  {31'd0, overflow},  {31'd0, x.ov});
      check({name, ".underflow"}, {31'd0, underflow}, {31'd0, x.uf});
      check({name, ".zero"},      {31'd0, zero},      {31'd0, x.z});
      @(negedge clk);
      check({name, ".done_width"}, {31'd0, done}, 32'd0);
      check({name, ".hold_fract"}, {6'd0, fract_out}, {6'd0, x.f});
      check({name, ".hold_exp"},   {24'd0, exp_out},  {24'd0, x.e});
    end
    if (inject_at > 0) begin
      extra = 0;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (done) extra++;
      end
      check({name, ".ignored_start"}, extra, 32'd0);
      check({name, ".busy_after"}, {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    int extra;
    reset = 1'b1; start = 1'b0; carry_in = 1'b0; fract_in = '0; exp_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    run_op("normalized", 1'b0, 26'h2000008, 8'd127, 26'h2000008, 8'd127, 1'b0, 1'b0, 1'b0, 2, 0);
    run_op("carry",      1'b1, 26'h0000003, 8'd100, 26'h2000001, 8'd101, 1'b0, 1'b0, 1'b0, 3, 0);
    run_op("bit20",      1'b0, 26'h0100000, 8'd50,  26'h2000000, 8'd45,  1'b0, 1'b0, 1'b0, 7, 3);
    run_op("zero",       1'b0, 26'h0000000, 8'd80,  26'h0000000, 8'd0,   1'b0, 1'b0, 1'b1, 2, 0);
    run_op("underflow",  1'b0, 26'h0000010, 8'd3,   26'h0000040, 8'd1,   1'b0, 1'b1, 1'b0, 4, 0);
    run_op("overflow",   1'b1, 26'h3FFFFFF, 8'd254, 26'h0000000, 8'd255, 1'b1, 1'b0, 1'b0, 2, 0);
    run_op("exp_max_in", 1'b0, 26'h2000000, 8'd255, 26'h0000000, 8'd255, 1'b1, 1'b0, 1'b0, 2, 0);
    run_op("bit0",       1'b0, 26'h0000001, 8'd100, 26'h2000000, 8'd75,  1'b0, 1'b0, 1'b0, 27, 0);

    // Reset in the middle of a long normalization.
    @(negedge clk);
    carry_in = 1'b0; fract_in = 26'h0000001; exp_in = 8'd100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("midreset.busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_all_zero("midreset");
    extra = 0;
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    check("midreset.no_done", extra, 32'd0);

    run_op("recover", 1'b1, 26'h0000002, 8'd10, 26'h2000001, 8'd11, 1'b0, 1'b0, 1'b0, 3, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
